// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM states and
// a helper that maps an op code onto the two slice select lines.
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD = 2'b00;
    localparam alu_op_t ALU_OP_AND = 2'b01;
    localparam alu_op_t ALU_OP_OR  = 2'b10;
    localparam alu_op_t ALU_OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Slice select lines are {op1, op0}; op1 is the MSB of the op code.
    function automatic logic op_hi(input alu_op_t op);
        return op[1];
    endfunction

    function automatic logic op_lo(input alu_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/bitwiseblock.sv
// One-bit ALU slice: full adder for ADD, plain gates for AND/OR/XOR.
// Logic ops never produce a carry out.
module bitwiseblock (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op1,
    input  logic op0,
    output logic q,
    output logic cout
);

    always_comb begin
        q    = 1'b0;
        cout = 1'b0;
        case ({op1, op0})
            2'b00: begin
                q    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            2'b01:   q = a & b;
            2'b10:   q = a | b;
            default: q = a ^ b;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: streams operands LSB-first through one bitwiseblock,
// assembles the result with carry and zero flags, and hands it off on valid/ready.
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    alu_state_t       r_state;
    alu_op_t          r_op;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic             r_zacc;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_q;
    logic             w_cout;

    bitwiseblock u_slice (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .op1  (op_hi(r_op)),
        .op0  (op_lo(r_op)),
        .q    (w_q),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= ALU_OP_ADD;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_result    <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_zacc      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_op       <= op;
                        r_a_sh     <= a_in;
                        r_b_sh     <= b_in;
                        r_carry    <= cin0;
                        r_count    <= '0;
                        r_result   <= '0;
                        r_zacc     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result fills from the top so bit 0 lands at result[0] after WIDTH shifts.
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_result <= {w_q, r_result[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_zacc   <= r_zacc & ~w_q;
                    r_count  <= r_count + CNT_W'(1);
                    if (r_count == LAST_BIT) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_carry;
    assign zero      = r_zacc;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized self-checking bench for serial_alu_seq against an arithmetic reference model.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin0 = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;

    int total = 0;
    int bad = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin0      (cin0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: {carry, result} from plain arithmetic on whole words.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic c);
        case (o)
            2'b00:   return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            2'b01:   return {1'b0, a & b};
            2'b10:   return {1'b0, a | b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // Presents one operand set for a single accept edge, then scrambles the inputs.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        @(negedge clk);
        op = o; a_in = a; b_in = b; cin0 = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom); cin0 = 1'($urandom);
    endtask

    // Counts negedges until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
        logic [W:0] m;
        int n;
        m = model(o, a, b, c);
        issue(o, a, b, c);
        wait_done(n);
        $display("%s: op=%0d a=%h b=%h cin=%b -> result=%h cout=%b zero=%b (cycles=%0d)",
                 name, o, a, b, c, result, cout, zero, n);
        total++;
        if (n !== W) begin
            bad++; $display("FAIL %s latency: got %0d cycles, need %0d", name, n, W);
        end
        total++;
        if (result !== m[W-1:0]) begin
            bad++; $display("FAIL %s result: got %h, need %h", name, result, m[W-1:0]);
        end
        total++;
        if (cout !== m[W]) begin
            bad++; $display("FAIL %s cout: got %b, need %b", name, cout, m[W]);
        end
        total++;
        if (zero !== (m[W-1:0] == '0)) begin
            bad++; $display("FAIL %s zero: got %b, need %b", name, zero, (m[W-1:0] == '0));
        end
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL %s handoff: in_ready=%b out_valid=%b, need 1/0",
                            name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1; out_ready = 1'($urandom);
        op = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom); cin0 = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
            bad++; $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h cout=%b zero=%b, need 1 0 00 0 0",
                            in_ready, out_valid, result, cout, zero);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
                bad++; $display("FAIL idle_hold[%0d]: in_ready=%b out_valid=%b result=%h cout=%b zero=%b",
                                i, in_ready, out_valid, result, cout, zero);
            end
        end
        $display("reset: idle state verified");
    endtask

    task automatic test_add;
        run_and_check("add_0f_01", 2'b00, 8'h0F, 8'h01, 1'b0);
        run_and_check("add_ff_01", 2'b00, 8'hFF, 8'h01, 1'b0);
        run_and_check("add_cin",   2'b00, 8'h7F, 8'h80, 1'b1);
    endtask

    task automatic test_logic;
        run_and_check("and", 2'b01, 8'hA5, 8'h0F, 1'b1);
        run_and_check("or",  2'b10, 8'hA0, 8'h0A, 1'b1);
        run_and_check("xor", 2'b11, 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_backpressure;
        logic [W:0] m;
        logic [W-1:0] a, b;
        int n;
        a = W'($urandom); b = W'($urandom);
        m = model(2'b00, a, b, 1'b0);
        issue(2'b00, a, b, 1'b0);
        wait_done(n);
        total++;
        if (n !== W) begin
            bad++; $display("FAIL bp_latency: got %0d cycles, need %0d", n, W);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2); a_in = W'($urandom); b_in = W'($urandom); op = 2'($urandom);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== m[W-1:0] || cout !== m[W]) begin
                bad++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h cout=%b, need 1 0 %h %b",
                                i, out_valid, in_ready, result, cout, m[W-1:0], m[W]);
            end
        end
        in_valid = 1'b0;
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== m[W-1:0]) begin
            bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b result=%h, need 1 0 %h",
                            in_ready, out_valid, result, m[W-1:0]);
        end
        $display("backpressure: a=%h b=%h -> result=%h held 10 cycles", a, b, result);
    endtask

    task automatic test_reset_mid_run;
        issue(2'b00, 8'hFF, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
            bad++; $display("FAIL midrun_reset: in_ready=%b out_valid=%b result=%h cout=%b zero=%b, need 1 0 00 0 0",
                            in_ready, out_valid, result, cout, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("after_reset", 2'b00, 8'h12, 8'h34, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] av[4], bv[4];
        logic         cv[4];
        logic [W:0]   mv[4];
        int sent = 0, got = 0, last = -100;
        for (int i = 0; i < 4; i++) begin
            av[i] = W'($urandom); bv[i] = W'($urandom); cv[i] = 1'($urandom);
            mv[i] = model(2'b00, av[i], bv[i], cv[i]);
        end
        op = 2'b00; out_ready = 1'b1; in_valid = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (got < 4) begin
                    $display("b2b[%0d]: a=%h b=%h cin=%b -> result=%h cout=%b at cycle %0d",
                             got, av[got], bv[got], cv[got], result, cout, cyc);
                    total++;
                    if (result !== mv[got][W-1:0] || cout !== mv[got][W]) begin
                        bad++; $display("FAIL b2b_result[%0d]: got %h/%b, need %h/%b",
                                        got, result, cout, mv[got][W-1:0], mv[got][W]);
                    end
                end
                if (got > 0) begin
                    total++;
                    if (cyc - last !== W + 2) begin
                        bad++; $display("FAIL b2b_spacing[%0d]: got %0d cycles, need %0d", got, cyc - last, W + 2);
                    end
                end
                last = cyc;
                got++;
            end
            if (in_ready === 1'b1 && sent < 4) begin
                a_in = av[sent]; b_in = bv[sent]; cin0 = cv[sent]; in_valid = 1'b1;
                sent++;
            end else if (in_ready === 1'b0 && sent == 4) begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0; in_valid = 1'b0;
        total++;
        if (got !== 4) begin
            bad++; $display("FAIL b2b_count: got %0d results, need 4", got);
        end
    endtask

    task automatic test_random;
        logic [1:0] o;
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom_range(0, 3));
            run_and_check("random", o, W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
